// File: rtl/collatz_range_engine.sv
// ============================================================================
// Module   : collatz_range_engine
// Brief    : Computes Collatz sequence lengths for RAM_WORDS consecutive start
//            values into an internal RAM; results read back by address n.
//            Optional macro COLLATZ_OVERFLOW_EN adds a sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module collatz_range_engine #(
    parameter int RAM_WORDS     = 256,
    parameter int RAM_ADDR_BITS = 8,
    parameter int COUNT_BITS    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     go,
    input  logic [31:0]              start,
    output logic                     done,
    input  logic [RAM_ADDR_BITS-1:0] n,
    output logic [COUNT_BITS-1:0]    count
`ifdef COLLATZ_OVERFLOW_EN
    ,
    output logic                     overflow
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ITER  = 2'd1,
        S_STORE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [RAM_ADDR_BITS-1:0] c_LAST_INDEX = RAM_ADDR_BITS'(RAM_WORDS - 1);
    localparam logic [31:0]              c_ODD_LIMIT  = 32'h5555_5554;

    state_t                   r_state;
    logic [31:0]              r_base;
    logic [31:0]              r_cur;
    logic [RAM_ADDR_BITS-1:0] r_index;
    logic [COUNT_BITS-1:0]    r_len;
    logic [COUNT_BITS-1:0]    r_ram [RAM_WORDS];

    logic [COUNT_BITS-1:0]    w_len_inc;
    logic [31:0]              w_cur_odd;
    logic [31:0]              w_next_start;
    logic                     w_last;
    logic                     w_ram_we;

    // Length saturates rather than wrapping so a huge run never reads as short.
    assign w_len_inc    = (&r_len) ? r_len : r_len + COUNT_BITS'(1);
    assign w_cur_odd    = {r_cur[30:0], 1'b0} + r_cur + 32'd1;
    assign w_next_start = r_base + 32'(r_index) + 32'd1;
    assign w_last       = (r_index == c_LAST_INDEX);
    assign w_ram_we     = (r_state == S_STORE) && !go;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_base  <= 32'd0;
            r_cur   <= 32'd0;
            r_index <= '0;
            r_len   <= '0;
            done    <= 1'b0;
`ifdef COLLATZ_OVERFLOW_EN
            overflow <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            // go restarts from any state, so an in-flight run is simply abandoned.
            if (go) begin
                r_base  <= start;
                r_cur   <= start;
                r_index <= '0;
                r_len   <= (start == 32'd0) ? COUNT_BITS'(0) : COUNT_BITS'(1);
                r_state <= S_ITER;
`ifdef COLLATZ_OVERFLOW_EN
                overflow <= 1'b0;
`endif
            end else begin
                case (r_state)
                    S_ITER: begin
                        if (r_cur == 32'd1 || r_cur == 32'd0) begin
                            r_state <= S_STORE;
                        end else if (!r_cur[0]) begin
                            r_cur <= r_cur >> 1;
                            r_len <= w_len_inc;
                        end else begin
                            r_cur <= w_cur_odd;
                            r_len <= w_len_inc;
`ifdef COLLATZ_OVERFLOW_EN
                            if (r_cur > c_ODD_LIMIT) begin
                                overflow <= 1'b1;
                            end
`endif
                        end
                    end
                    S_STORE: begin
                        if (w_last) begin
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_index <= r_index + RAM_ADDR_BITS'(1);
                            r_cur   <= w_next_start;
                            r_len   <= COUNT_BITS'(1);
                            r_state <= S_ITER;
                        end
                    end
                    S_DONE:  r_state <= S_DONE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Result RAM has no reset so earlier results survive a reset.
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_ram[r_index] <= r_len;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= r_ram[n];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_collatz_range_engine.sv
// ============================================================================
// Module   : tb_collatz_range_engine
// Brief    : Self-checking bench for collatz_range_engine against a behavioural
//            Collatz model; a 4-word and a default-size instance share the clock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_collatz_range_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        go_s, go_b;
    logic [31:0] start_s, start_b;
    logic [1:0]  n_s;
    logic [7:0]  n_b;
    logic        done_s, done_b;
    logic [15:0] count_s, count_b;
`ifdef COLLATZ_OVERFLOW_EN
    logic        overflow_s, overflow_b;
`endif

    int checks = 0;
    int errors = 0;

    int exp_len [256];
    int exp_cycles;
    bit exp_ovf;

    always #5 clk = ~clk;

    collatz_range_engine #(.RAM_WORDS(4), .RAM_ADDR_BITS(2), .COUNT_BITS(16)) u_small (
        .clk     (clk),
        .reset   (rst),
        .go      (go_s),
        .start   (start_s),
        .done    (done_s),
        .n       (n_s),
        .count   (count_s)
`ifdef COLLATZ_OVERFLOW_EN
        ,
        .overflow(overflow_s)
`endif
    );

    collatz_range_engine u_big (
        .clk     (clk),
        .reset   (rst),
        .go      (go_b),
        .start   (start_b),
        .done    (done_b),
        .n       (n_b),
        .count   (count_b)
`ifdef COLLATZ_OVERFLOW_EN
        ,
        .overflow(overflow_b)
`endif
    );

    // Reference: walk the sequence with plain 32-bit arithmetic.
    task automatic model_range(input logic [31:0] base, input int words);
        logic [31:0] v;
        int          l;
        exp_cycles = 1;
        exp_ovf    = 1'b0;
        for (int i = 0; i < words; i++) begin
            v = base + 32'(i);
            if (v == 32'd0) begin
                l = 0;
            end else begin
                l = 1;
                for (int k = 0; k < 1000000 && v != 32'd1 && v != 32'd0; k++) begin
                    if (v % 2 == 1) begin
                        if (v > 32'h5555_5554) exp_ovf = 1'b1;
                        v = v * 32'd3 + 32'd1;
                    end else begin
                        v = v / 2;
                    end
                    if (l < 65535) l++;
                end
            end
            exp_len[i] = l;
            exp_cycles += l + 1;
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Returns cycles from the go cycle to the done cycle, or -1 on timeout.
    task automatic wait_done(input bit big, input int budget, output int cyc);
        cyc = -1;
        for (int e = 1; e <= budget; e++) begin
            tick();
            if ((big ? done_b : done_s) === 1'b1) begin
                cyc = e + 1;
                break;
            end
        end
    endtask

    task automatic pulse_go_small(input logic [31:0] s);
        start_s = s;
        go_s    = 1'b1;
        tick();
        go_s    = 1'b0;
    endtask

    task automatic check_small_entries(input string tag);
        for (int i = 0; i < 4; i++) begin
            n_s = 2'(i);
            tick();
            checks++;
            if (count_s !== 16'(exp_len[i])) begin
                errors++;
                $display("FAIL %s n=%0d: count=%0d expected=%0d", tag, i, count_s, exp_len[i]);
            end
        end
    endtask

    task automatic check_run_small(input string tag);
        int cyc;
        wait_done(1'b0, 20000, cyc);
        checks++;
        if (cyc != exp_cycles) begin
            errors++;
            $display("FAIL %s latency: got=%0d expected=%0d", tag, cyc, exp_cycles);
        end
        tick();
        checks++;
        if (done_s !== 1'b0) begin
            errors++;
            $display("FAIL %s done_width: done=%b expected=0", tag, done_s);
        end
        check_small_entries(tag);
    endtask

    task automatic test_reset;
        rst = 1'b1; go_s = 0; go_b = 0; start_s = 0; start_b = 0; n_s = 0; n_b = 0;
        tick(); tick();
        checks++;
        if (done_s !== 1'b0 || done_b !== 1'b0 || count_s !== 16'd0 || count_b !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: done=%b/%b count=%0d/%0d expected 0", done_s, done_b, count_s, count_b);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_small_basic;
        model_range(32'd1, 4);
        pulse_go_small(32'd1);
        check_run_small("basic_start1");
    endtask

    task automatic test_random_small;
        logic [31:0] s;
        for (int r = 0; r < 4; r++) begin
            s = 32'($urandom_range(1, 32'h00FF_FFFF));
            model_range(s, 4);
            pulse_go_small(s);
            check_run_small("random_small");
        end
    endtask

    task automatic test_default_table;
        int cyc;
        model_range(32'd1, 256);
        start_b = 32'd1;
        go_b    = 1'b1;
        tick();
        go_b    = 1'b0;
        wait_done(1'b1, 60000, cyc);
        checks++;
        if (cyc != exp_cycles) begin
            errors++;
            $display("FAIL default_latency: got=%0d expected=%0d", cyc, exp_cycles);
        end
        n_b = 8'd26;
        tick();
        checks++;
        if (count_b !== 16'd112) begin
            errors++;
            $display("FAIL default_n26: count=%0d expected=112", count_b);
        end
        n_b = 8'd255;
        tick();
        checks++;
        if (count_b !== 16'd9) begin
            errors++;
            $display("FAIL default_n255: count=%0d expected=9", count_b);
        end
        for (int k = 0; k < 16; k++) begin
            n_b = 8'($urandom_range(0, 255));
            tick();
            checks++;
            if (count_b !== 16'(exp_len[n_b])) begin
                errors++;
                $display("FAIL default_rand n=%0d: count=%0d expected=%0d", n_b, count_b, exp_len[n_b]);
            end
        end
    endtask

    task automatic test_go_held;
        int cyc;
        bit early;
        model_range(32'd5, 4);
        start_s = 32'd5;
        go_s    = 1'b1;
        early   = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (done_s !== 1'b0) early = 1'b1;
        end
        go_s = 1'b0;
        checks++;
        if (early) begin
            errors++;
            $display("FAIL go_held_early_done: done=1 expected=0 while go held");
        end
        check_run_small("go_held");
    endtask

    task automatic test_restart;
        bit early;
        model_range(32'd100, 4);
        pulse_go_small(32'd27);
        early = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (done_s !== 1'b0) early = 1'b1;
        end
        pulse_go_small(32'd100);
        checks++;
        if (early || done_s !== 1'b0) begin
            errors++;
            $display("FAIL restart_early_done: done=1 expected=0 before restart completes");
        end
        check_run_small("restart100");
        checks++;
        if (exp_len[0] != 26) begin
            errors++;
            $display("FAIL restart_model n=0: model=%0d expected=26", exp_len[0]);
        end
    endtask

    task automatic test_async_reset;
        bit spurious;
        n_s = 2'd0;
        tick();
        pulse_go_small(32'd27);
        for (int c = 0; c < 10; c++) tick();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (done_s !== 1'b0 || count_s !== 16'd0) begin
            errors++;
            $display("FAIL async_reset: done=%b count=%0d expected 0/0", done_s, count_s);
        end
        tick(); tick();
        rst = 1'b0;
        spurious = 1'b0;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (done_s !== 1'b0) spurious = 1'b1;
        end
        checks++;
        if (spurious) begin
            errors++;
            $display("FAIL reset_no_done: done pulsed after reset without go");
        end
        checks++;
        if (count_s !== 16'd26) begin
            errors++;
            $display("FAIL reset_ram_kept: count=%0d expected=26", count_s);
        end
    endtask

`ifdef COLLATZ_OVERFLOW_EN
    task automatic test_overflow;
        model_range(32'h5555_5555, 4);
        pulse_go_small(32'h5555_5555);
        check_run_small("overflow_run");
        checks++;
        if (overflow_s !== exp_ovf || exp_ovf !== 1'b1) begin
            errors++;
            $display("FAIL overflow_set: overflow=%b expected=1", overflow_s);
        end
        model_range(32'd1, 4);
        pulse_go_small(32'd1);
        checks++;
        if (overflow_s !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clear: overflow=%b expected=0", overflow_s);
        end
        check_run_small("overflow_clear_run");
    endtask
`endif

    initial begin
        test_reset();
        test_small_basic();
        test_random_small();
        test_default_table();
        test_go_held();
        test_restart();
        test_async_reset();
`ifdef COLLATZ_OVERFLOW_EN
        test_overflow();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
